// File: rtl/alu_mult_sequencer.sv
// Shift-and-add 64-bit multiplier controller that borrows the datapath ALU for its adds.
// Optional early termination when the remaining multiplier is zero: ALU_MULT_EARLY_TERM_EN.
module alu_mult_sequencer #(
    parameter int          WIDTH      = 64,
    parameter logic [3:0]  CTRL_ADD   = 4'b0010,
    parameter logic [3:0]  CTRL_PASSB = 4'b0111
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mult_a,
    input  logic [WIDTH-1:0] i_mult_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [3:0]       o_alu_ctrl,
    input  logic [WIDTH-1:0] i_alu_w
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CW-1:0]     r_count;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_product;
    logic [WIDTH-1:0]  w_acc_next;
    logic [WIDTH-1:0]  w_mplier_shift;
    logic              w_last;

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

    always_comb begin
        w_state_next   = r_state;
        o_alu_a        = '0;
        o_alu_b        = '0;
        o_alu_ctrl     = CTRL_PASSB;
        w_acc_next     = r_mplier[0] ? i_alu_w : r_acc;
        w_mplier_shift = r_mplier >> 1;
`ifdef ALU_MULT_EARLY_TERM_EN
        w_last         = (w_mplier_shift == '0) || (r_count == LAST);
`else
        w_last         = (r_count == LAST);
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                // ALU computes acc + mcand; only committed when the multiplier bit is set
                o_alu_a    = r_acc;
                o_alu_b    = r_mcand;
                o_alu_ctrl = CTRL_ADD;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand  <= i_mult_a;
                        r_mplier <= i_mult_b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shift;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_product <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer with a behavioural model of the datapath ALU.
module tb_alu_mult_sequencer;

    localparam int         W      = 64;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_PASS = 4'b0111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  mult_a = '0;
    logic [W-1:0]  mult_b = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  product;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_w;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_done = 1'b0;

    always #5 clk = ~clk;

    // Reference ALU: add, pass-B, otherwise zero
    always_comb begin
        alu_w = '0;
        if (alu_ctrl == C_ADD)       alu_w = alu_a + alu_b;
        else if (alu_ctrl == C_PASS) alu_w = alu_b;
    end

    alu_mult_sequencer dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mult_a   (mult_a),
        .i_mult_b   (mult_b),
        .o_busy     (busy),
        .o_done     (done),
        .o_product  (product),
        .o_alu_a    (alu_a),
        .o_alu_b    (alu_b),
        .o_alu_ctrl (alu_ctrl),
        .i_alu_w    (alu_w)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int run_cycles(input logic [W-1:0] b);
`ifdef ALU_MULT_EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i;
        return (b == '0) ? 1 : m + 1;
`else
        return W;
`endif
    endfunction

    // Output monitor: pops the scoreboard on every Done pulse, checks ALU control every cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("extra_done", 64'(done), 64'(0));
                end else begin
                    check("product", product, exp_q.pop_front());
                end
                check("busy_in_done", 64'(busy), 64'(1));
                check("done_one_cycle", 64'(prev_done), 64'(0));
            end
            if (busy && !done) begin
                check("ctrl_run", 64'(alu_ctrl), 64'(C_ADD));
            end else begin
                check("ctrl_idle", 64'(alu_ctrl), 64'(C_PASS));
                check("alua_idle", alu_a, '0);
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // Runs one multiply; returns edges after the Start edge until Done appears (0 = timeout)
    task automatic wait_done(output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            check("done_timeout", 64'(0), 64'(1));
            n = 0;
        end
    endtask

    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic [W-1:0] p;
        p = a * b;
        @(negedge clk);
        start  = 1'b1;
        mult_a = a;
        mult_b = b;
        exp_q.push_back(p);
        @(posedge clk);
        #1 start = 1'b0;
        mult_a = '0;
        mult_b = '0;
        wait_done(n);
        if (n != 0) check("latency", 64'(n), 64'(run_cycles(b)));
        @(negedge clk);
        check("product_hold", product, p);
        check("busy_after", 64'(busy), 64'(0));
        $display("mult a=%h b=%h exp=%h prod=%h lat=%0d", a, b, p, product, n);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_product", product, '0);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ctrl", 64'(alu_ctrl), 64'(C_PASS));
        rst = 1'b0;
        @(negedge clk);

        do_mult(64'd3, 64'd5);
        do_mult(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        do_mult(64'h8000_0000_0000_0000, 64'd2);
        do_mult(64'h1234, 64'd0);
        do_mult(64'd1, 64'h8000_0000_0000_0001);
        do_mult(64'd1, 64'd4);
        do_mult(-64'sd3, 64'd7);
        for (int i = 0; i < 4; i++) begin
            do_mult({$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 60));
        end

        // Start held high with operands changed mid-run: only the captured op completes
        @(negedge clk);
        start  = 1'b1;
        mult_a = 64'd3;
        mult_b = 64'd5;
        exp_q.push_back(64'd15);
        @(posedge clk);
        #1 mult_a = 64'd7;
        mult_b = 64'd7;
        wait_done(n);
        if (n != 0) check("held_latency", 64'(n), 64'(run_cycles(64'd5)));
        start = 1'b0;
        @(negedge clk);
        check("held_idle", 64'(busy), 64'(0));
        check("held_product", product, 64'd15);
        $display("held_start prod=%h", product);
        do_mult(64'd7, 64'd7);

        // Mid-run reset discards the operation
        @(negedge clk);
        start  = 1'b1;
        mult_a = 64'd3;
        mult_b = 64'h8000_0000_0000_0005;
        exp_q.push_back(64'd3 * 64'h8000_0000_0000_0005);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_product", product, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst_done", 64'(done), 64'(0));
        $display("mid_run_reset prod=%h busy=%0d", product, busy);
        do_mult(64'd6, 64'd7);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mult_sequencer.md
# alu_mult_sequencer

Multi-cycle 64-bit multiplier controller that computes products without a hardware multiplier. It drives the existing 64-bit ALU's operand and control inputs with a shift-and-add sequence and reads back its result bus. It sits beside the single-cycle datapath and owns the ALU port mux while a multiply is in flight. It returns the low 64 bits of the product with a start/done handshake.

## Interface
- WIDTH, 64, operand/product width; must equal ALU bus width
- CTRL_ADD, 4'b0010, ALU control code for add
- CTRL_PASSB, 4'b0111, ALU control code driven while idle

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request a multiply; sampled only in IDLE
- MultA  in  WIDTH  multiplicand, captured with Start
- MultB  in  WIDTH  multiplier, captured with Start
- Busy  out  1  high in RUN and DONE
- Done  out  1  one-cycle pulse; Product valid from this cycle
- Product  out  WIDTH  registered low WIDTH bits of MultA*MultB
- AluA  out  WIDTH  to ALU BusA
- AluB  out  WIDTH  to ALU BusB
- AluCtrl  out  4  to ALU ALUCtrl
- AluW  in  WIDTH  from ALU BusW (combinational ALU result)

## Operation
- States: IDLE, RUN, DONE. Reset: state=IDLE, Product=0, Done=0, Busy=0, internal acc/mcand/mplier/count=0.
- IDLE: AluA=0, AluB=0, AluCtrl=CTRL_PASSB. Start=1 -> mcand<=MultA, mplier<=MultB, acc<=0, count<=0, go RUN.
- RUN, every cycle: AluA=acc, AluB=mcand, AluCtrl=CTRL_ADD.
  - mplier[0]=1 -> acc<=AluW; else acc holds.
  - mcand<=mcand<<1 (zero fill, MSB discarded); mplier<=mplier>>1; count<=count+1.
  - count==WIDTH-1 -> go DONE, Product<=next acc value.
- DONE: Done=1 for exactly this cycle, Busy=1, ALU outputs as IDLE; next cycle IDLE.
- Arithmetic: unsigned, all sums modulo 2^WIDTH; overflow silently wraps, no flag. Signed operands yield correct low WIDTH bits (two's complement).
- Start in RUN or DONE is ignored; operands not recaptured. No queuing.
- Product holds its value until the next DONE or Reset.
- Reset asserted mid-operation: immediately IDLE, partial result discarded, Product=0, no Done pulse.

## Timing
- Start sampled at edge 0 -> RUN cycles 1..WIDTH -> Done high in cycle WIDTH+1 (65 for default), Product valid same cycle.
- Earliest next Start accepted: cycle WIDTH+2 (back in IDLE).
- AluW is consumed combinationally in the same cycle the sequencer drives AluA/AluB; the ALU path plus acc setup must close in one Clk period.
- All outputs except AluA/AluB/AluCtrl are registered; ALU outputs decode from state and registers only (no input-to-output combinational path).

## Configuration
- ALU_MULT_EARLY_TERM_EN defined: in RUN, go DONE after any cycle where the shifted mplier becomes 0. RUN lasts max(1, msb(MultB)+1) cycles; MultB=0 -> 1 RUN cycle, Done in cycle 2. Product value identical to full run.
- Not defined: RUN always lasts exactly WIDTH cycles regardless of operands; fixed latency WIDTH+1.

## Test plan
- MultA=3, MultB=5, Start 1 cycle -> Done pulse in cycle 65 (no early term), Product=15, AluCtrl=0010 throughout RUN, 0111 in IDLE.
- MultA=64'hFFFF_FFFF_FFFF_FFFF, MultB=2 -> Product=64'hFFFF_FFFF_FFFF_FFFE (wrap); MultA=64'h8000_0000_0000_0000, MultB=2 -> Product=0.
- MultB=0, MultA=64'h1234 -> Product=0; with ALU_MULT_EARLY_TERM_EN Done in cycle 2, without it cycle 65.
- Start held high through a multiply with operands changed mid-run to 7/7 -> result of originally captured 3*5=15, only one Done pulse, new op begins only after returning to IDLE.
- Reset asserted in cycle 20 of a 3*5 run -> Busy=0, Done never pulses, Product=0; fresh Start 6*7 then yields 42.
- ALU_MULT_EARLY_TERM_EN, MultB=64'h8000_0000_0000_0001, MultA=1 -> full 64 RUN cycles, Product=64'h8000_0000_0000_0001; MultB=4 -> 3 RUN cycles, Done in cycle 4, Product=4.
